// File: rtl/char_mem_sched.sv
// Single-port char_memory arbiter: renderer reads win, host glyph loads fill free cycles.
// Optional read-back check of each loaded glyph under CHAR_MEM_SCHED_VERIFY_EN.
module char_mem_sched #(
    parameter int COLS = 4,
    parameter int ROWS = 5,
    parameter int XW   = 2,
    parameter int YW   = 3
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   rd_req,
    input  logic [XW-1:0]          rd_x,
    input  logic [YW-1:0]          rd_y,
    output logic                   rd_valid,
    output logic                   rd_data,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [COLS*ROWS-1:0]   ld_glyph,
    output logic                   ld_busy,
    output logic                   ld_done,
    output logic                   ld_err,
    output logic                   mem_write,
    output logic [XW-1:0]          mem_x,
    output logic [YW-1:0]          mem_y,
    output logic                   mem_data_in,
    input  logic                   mem_data_out
);

    localparam int CELLS = COLS * ROWS;
    localparam int CW    = $clog2(CELLS);

`ifdef CHAR_MEM_SCHED_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        VERIFY,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CELLS-1:0] glyph;
    logic [CW-1:0]    cnt;
    logic             free;
    logic             last;
    logic             active;
    logic             accept;
    logic [XW-1:0]    cnt_x;
    logic [YW-1:0]    cnt_y;

    assign free   = !rd_req;
    assign last   = (cnt == CW'(CELLS - 1));
    assign active = (state == LOAD) || (state == VERIFY);
    assign accept = ld_valid && ld_ready;
    assign cnt_x  = XW'(32'(cnt) % COLS);
    assign cnt_y  = YW'(32'(cnt) / COLS);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (ld_valid) state_nxt = LOAD;
            LOAD:   if (free && last) state_nxt = VERIFY_EN ? VERIFY : DONE;
            VERIFY: if (free && last) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Display requests own the port outright; the loader only sees leftover cycles.
    always_comb begin
        ld_ready    = (state == IDLE);
        ld_busy     = active;
        ld_done     = (state == DONE);
        mem_write   = 1'b0;
        mem_x       = '0;
        mem_y       = '0;
        mem_data_in = 1'b0;
        if (rd_req) begin
            mem_x = rd_x;
            mem_y = rd_y;
        end else if (state == LOAD) begin
            mem_write   = 1'b1;
            mem_x       = cnt_x;
            mem_y       = cnt_y;
            mem_data_in = glyph[cnt];
        end else if (state == VERIFY) begin
            mem_x = cnt_x;
            mem_y = cnt_y;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            glyph <= '0;
            cnt   <= '0;
        end else begin
            if (accept) begin
                glyph <= ld_glyph;
                cnt   <= '0;
            end else if (active && free) begin
                cnt <= last ? '0 : cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= mem_data_out;
            end
        end
    end

`ifdef CHAR_MEM_SCHED_VERIFY_EN
    logic err_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (state == VERIFY && free && mem_data_out != glyph[cnt]) begin
            err_q <= 1'b1;
        end
    end

    assign ld_err = err_q;
`else
    assign ld_err = 1'b0;
`endif

endmodule

// File: tb/tb_char_mem_sched.sv
// Scoreboard bench for char_mem_sched with a behavioural char_memory and
// a spec-level model of load progress and memory contents.
module tb_char_mem_sched;

`ifdef CHAR_MEM_SCHED_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic        clock;
    logic        rst;
    logic        rd_req;
    logic [1:0]  rd_x;
    logic [2:0]  rd_y;
    logic        rd_valid;
    logic        rd_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [19:0] ld_glyph;
    logic        ld_busy;
    logic        ld_done;
    logic        ld_err;
    logic        mem_write;
    logic [1:0]  mem_x;
    logic [2:0]  mem_y;
    logic        mem_data_in;
    logic        mem_data_out;

    char_mem_sched dut (
        .clock        (clock),
        .rst          (rst),
        .rd_req       (rd_req),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_glyph     (ld_glyph),
        .ld_busy      (ld_busy),
        .ld_done      (ld_done),
        .ld_err       (ld_err),
        .mem_write    (mem_write),
        .mem_x        (mem_x),
        .mem_y        (mem_y),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // behavioural char_memory, optional stuck-at-0 on cell (y=1,x=2)
    logic [19:0] mem_arr = '0;
    bit          stuck_en = 1'b0;
    int          mem_idx;

    always @(posedge clock) begin
        if (mem_write && mem_y < 3'd5)
            mem_arr[int'(mem_y) * 4 + int'(mem_x)] <= mem_data_in;
    end

    always_comb begin
        mem_idx = int'(mem_y) * 4 + int'(mem_x);
        mem_data_out = 1'b0;
        if (mem_y < 3'd5 && !(stuck_en && mem_idx == 6))
            mem_data_out = mem_arr[mem_idx];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input bit ok, input string name,
                       input int act, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    // reference model: phase 0 idle, 1 load, 2 verify, 3 done
    bit          ref_mem [20];
    logic [19:0] g_m    = '0;
    int          ph     = 0;
    int          prog   = 0;
    bit          err_m  = 1'b0;
    bit          exp_rv = 1'b0;
    bit          rd_q [$];

    function automatic bit cell_val(input int i);
        if (i < 0 || i > 19) return 1'b0;
        if (stuck_en && i == 6) return 1'b0;
        return ref_mem[i];
    endfunction

    always @(posedge clock or posedge rst) begin
        if (rst) begin
            ph = 0;
            prog = 0;
            err_m = 1'b0;
            exp_rv = 1'b0;
            rd_q.delete();
        end else begin
            exp_rv = rd_req;
            if (rd_req)
                rd_q.push_back(rd_y < 3'd5 ?
                    cell_val(int'(rd_y) * 4 + int'(rd_x)) : 1'b0);
            case (ph)
                0: if (ld_valid) begin
                    g_m = ld_glyph;
                    ph = 1;
                    prog = 0;
                    err_m = 1'b0;
                end
                1: if (!rd_req) begin
                    ref_mem[prog] = g_m[prog];
                    prog++;
                    if (prog == 20) begin
                        prog = 0;
                        ph = VERIFY ? 2 : 3;
                    end
                end
                2: if (!rd_req) begin
                    if (cell_val(prog) != g_m[prog]) err_m = 1'b1;
                    prog++;
                    if (prog == 20) begin
                        prog = 0;
                        ph = 3;
                    end
                end
                default: ph = 0;
            endcase
        end
    end

    bit mon_en = 1'b0;

    always @(negedge clock) begin
        if (mon_en) begin
            chk(ld_ready == (ph == 0), "ld_ready", ld_ready, ph == 0);
            chk(ld_busy == (ph == 1 || ph == 2), "ld_busy", ld_busy, ph);
            chk(ld_done == (ph == 3), "ld_done", ld_done, ph == 3);
            chk(ld_err == err_m, "ld_err", ld_err, err_m);
            chk(mem_write == (ph == 1 && !rd_req), "mem_write",
                mem_write, ph == 1 && !rd_req);
            if (rd_req)
                chk(mem_x == rd_x && mem_y == rd_y, "rd_grant_xy",
                    {mem_y, mem_x}, {rd_y, rd_x});
            else if (ph == 1)
                chk(mem_x == 2'(prog % 4) && mem_y == 3'(prog / 4)
                    && mem_data_in == g_m[prog], "wr_cell",
                    {mem_data_in, mem_y, mem_x}, prog);
            chk(rd_valid == exp_rv, "rd_valid", rd_valid, exp_rv);
            if (rd_valid && exp_rv) begin
                if (rd_q.size() == 0) begin
                    chk(1'b0, "rd_q_empty", rd_data, 0);
                end else begin
                    bit e;
                    e = rd_q.pop_front();
                    chk(rd_data == e, "rd_data", rd_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rd(input bit req);
        rd_req = req;
        rd_x = 2'($urandom_range(0, 3));
        rd_y = 3'($urandom_range(0, 7));
    endtask

    // mode: 0 quiet, 1 toggle reads, 2 random reads, 3 quiet + stray offer
    task automatic do_load(input logic [19:0] g, input int mode,
                           output int lat);
        int n;
        ld_valid = 1'b1;
        ld_glyph = g;
        rd_req = 1'b0;
        tick();
        ld_valid = 1'b0;
        ld_glyph = 20'($urandom);
        n = 0;
        do begin
            n++;
            case (mode)
                1: set_rd(n % 2 == 0);
                2: set_rd($urandom_range(0, 99) < 40);
                default: set_rd(1'b0);
            endcase
            if (mode == 3 && n == 5) begin
                ld_valid = 1'b1;
                ld_glyph = 20'h00000;
                chk(ld_ready == 1'b0, "busy_ready", ld_ready, 0);
            end else begin
                ld_valid = 1'b0;
            end
            tick();
        end while (!ld_done && n < 400);
        chk(ld_done == 1'b1, "load_timeout", n, 0);
        lat = n + 1;
        ld_valid = 1'b0;
        rd_req = 1'b0;
        tick();
    endtask

    task automatic read_all();
        for (int i = 0; i < 24; i++) begin
            rd_req = 1'b1;
            rd_x = 2'(i % 4);
            rd_y = 3'(i / 4);
            tick();
        end
        rd_req = 1'b0;
        tick();
        tick();
    endtask

    int lat;

    initial begin
        rst = 1'b1;
        rd_req = 1'b0;
        rd_x = '0;
        rd_y = '0;
        ld_valid = 1'b0;
        ld_glyph = '0;
        #3;
        chk(rd_valid == 0 && rd_data == 0, "rst_rd", rd_data, 0);
        chk(ld_ready == 1'b1, "rst_ready", ld_ready, 1);
        chk(ld_busy == 0 && ld_done == 0 && ld_err == 0, "rst_ld",
            {ld_busy, ld_done, ld_err}, 0);
        chk(mem_write == 0 && mem_x == 0 && mem_y == 0
            && mem_data_in == 0, "rst_mem", mem_write, 0);
        tick();
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        do_load(20'hA5A5A, 0, lat);
        chk(lat == (VERIFY ? 41 : 21), "lat_quiet", lat, VERIFY ? 41 : 21);
        rd_req = 1'b1;
        rd_x = 2'd2;
        rd_y = 3'd1;
        tick();
        rd_req = 1'b0;
        chk(rd_valid == 1'b1 && rd_data == 1'b1, "read_y1x2",
            {rd_valid, rd_data}, 3);
        tick();
        read_all();

        do_load(20'hFFFFF, 1, lat);
        chk(lat == (VERIFY ? 80 : 40), "lat_toggle", lat, VERIFY ? 80 : 40);
        read_all();

        do_load(20'h3C3C3, 3, lat);
        read_all();

        // reset after cell 7 written
        ld_valid = 1'b1;
        ld_glyph = 20'h5A5A5;
        tick();
        ld_valid = 1'b0;
        repeat (8) tick();
        #2;
        rst = 1'b1;
        #1;
        chk(ld_ready == 1'b1 && ld_busy == 1'b0 && mem_write == 1'b0,
            "mid_rst", {ld_ready, ld_busy, mem_write}, 4);
        tick();
        rst = 1'b0;
        tick();
        read_all();

        stuck_en = 1'b1;
        do_load(20'hFFFFF, 0, lat);
        chk(ld_err == VERIFY, "stuck_err", ld_err, VERIFY);
        do_load(20'h00000, 0, lat);
        chk(ld_err == 1'b0, "stuck_clear", ld_err, 0);
        stuck_en = 1'b0;

        for (int r = 0; r < 6; r++) begin
            do_load(20'($urandom), 2, lat);
            for (int k = 0; k < 10; k++) begin
                set_rd($urandom_range(0, 1) == 1);
                tick();
            end
            rd_req = 1'b0;
            read_all();
        end

        mon_en = 1'b0;
        chk(rd_q.size() == 0, "rd_q_drain", rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
